// File: rtl/inst_rom_resp.sv
// ---------------------------------------------------------------------------
// inst_rom_resp -- instruction-memory responder for the fetch stage.
//
// Accepts one fetch request per cycle (ce, pc) and returns the addressed
// 32-bit word one cycle later, tagged with the request pc and an error flag.
// The word store is an inferred RAM with a registered read port, filled
// through a separate program-load write port.
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous reset, active-high (clears outputs, not the store)
//   ce          fetch request valid this cycle
//   pc          byte address of the requested instruction
//   inst        returned instruction word (NOP_WORD on disabled/errored fetch)
//   inst_pc     pc of the request that produced inst (holds when ce=0)
//   inst_valid  inst/inst_pc/fetch_err valid this cycle
//   fetch_err   request was misaligned or out of range
//   ld_we       program-load write strobe
//   ld_addr     word index to write
//   ld_data     word to write
//
// Optional feature (macro INST_ROM_STATS_EN):
//   fetch_cnt   count of accepted requests, wraps modulo 2^32
//   err_cnt     count of errored requests, saturates at 16'hFFFF
// ---------------------------------------------------------------------------
module inst_rom_resp #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [31:0]           pc,
  output logic [31:0]           inst,
  output logic [31:0]           inst_pc,
  output logic                  inst_valid,
  output logic                  fetch_err,
  input  logic                  ld_we,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [31:0]           ld_data
`ifdef INST_ROM_STATS_EN
  ,
  output logic [31:0]           fetch_cnt,
  output logic [15:0]           err_cnt
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // Word store; contents survive reset.
  logic [31:0] mem [0:DEPTH-1];

  logic [DEPTH_LOG2-1:0] rd_index;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  err_next;
  logic                  use_mem_next;

  logic [31:0] rd_data_reg;
  logic        use_mem_reg;
  logic [31:0] inst_pc_reg;
  logic        valid_reg;
  logic        err_reg;

  assign rd_index     = pc[DEPTH_LOG2+1:2];
  assign misaligned   = (pc[1:0] != 2'b00);
  // Any address bit above the store's byte range means the fetch falls off
  // the end; the store does not wrap.
  assign out_of_range = ((pc >> (DEPTH_LOG2 + 2)) != 32'd0);
  assign err_next     = ce & (misaligned | out_of_range);
  assign use_mem_next = ce & ~(misaligned | out_of_range);

  // RAM port: write and registered read in the same process so a fetch that
  // hits the index being loaded sees the old word (read-before-write).
  always_ff @(posedge clk) begin
    if (ld_we) begin
      mem[ld_addr] <= ld_data;
    end
    rd_data_reg <= mem[rd_index];
  end

  // Response registers. The RAM output register cannot be reset, so a
  // registered select steers inst to NOP_WORD for reset/disabled/errored
  // cycles instead.
  always_ff @(posedge clk) begin
    if (rst) begin
      use_mem_reg <= 1'b0;
      inst_pc_reg <= 32'd0;
      valid_reg   <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      use_mem_reg <= use_mem_next;
      valid_reg   <= ce;
      err_reg     <= err_next;
      if (ce) begin
        inst_pc_reg <= pc;
      end
    end
  end

  assign inst       = use_mem_reg ? rd_data_reg : NOP_WORD;
  assign inst_pc    = inst_pc_reg;
  assign inst_valid = valid_reg;
  assign fetch_err  = err_reg;

`ifdef INST_ROM_STATS_EN
  logic [31:0] fetch_cnt_reg;
  logic [15:0] err_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_reg <= 32'd0;
      err_cnt_reg   <= 16'd0;
    end else begin
      if (ce) begin
        fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
      end
      if (err_next && (err_cnt_reg != 16'hFFFF)) begin
        err_cnt_reg <= err_cnt_reg + 16'd1;
      end
    end
  end

  assign fetch_cnt = fetch_cnt_reg;
  assign err_cnt   = err_cnt_reg;
`endif

endmodule

// File: tb/tb_inst_rom_resp.sv
// ---------------------------------------------------------------------------
// tb_inst_rom_resp -- directed self-checking bench for inst_rom_resp.
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// the rising edge that registers them. Stats counters are checked when
// INST_ROM_STATS_EN is defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_inst_rom_resp;

  logic        clk;
  logic        rst;
  logic        ce;
  logic [31:0] pc;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        fetch_err;
  logic        ld_we;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;
`ifdef INST_ROM_STATS_EN
  logic [31:0] fetch_cnt;
  logic [15:0] err_cnt;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  inst_rom_resp #(
    .DEPTH_LOG2(10),
    .NOP_WORD  (32'h0000_0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .pc        (pc),
    .inst      (inst),
    .inst_pc   (inst_pc),
    .inst_valid(inst_valid),
    .fetch_err (fetch_err),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data)
`ifdef INST_ROM_STATS_EN
    ,
    .fetch_cnt (fetch_cnt),
    .err_cnt   (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%08h", tag, got);
    end
  endtask

  // One clock cycle: drive inputs at negedge, return 1 unit after posedge.
  task automatic cyc(input logic rst_v, input logic ce_v, input logic [31:0] pc_v,
                     input logic we_v, input logic [9:0] addr_v, input logic [31:0] data_v);
    @(negedge clk);
    rst     = rst_v;
    ce      = ce_v;
    pc      = pc_v;
    ld_we   = we_v;
    ld_addr = addr_v;
    ld_data = data_v;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc_v);
    cyc(1'b0, 1'b1, pc_v, 1'b0, 10'd0, 32'd0);
  endtask

  task automatic load(input logic [9:0] addr_v, input logic [31:0] data_v);
    cyc(1'b0, 1'b0, 32'd0, 1'b1, addr_v, data_v);
  endtask

  // Check the full response of the most recent cycle.
  task automatic check_resp(input string tag, input logic v, input logic [31:0] i,
                            input logic [31:0] p, input logic e);
    check({tag, ".valid"}, {31'd0, inst_valid}, {31'd0, v});
    check({tag, ".inst"},  inst, i);
    check({tag, ".pc"},    inst_pc, p);
    check({tag, ".err"},   {31'd0, fetch_err}, {31'd0, e});
  endtask

  logic [31:0] prog [0:3];

  initial begin
    rst = 1'b1; ce = 1'b0; pc = 32'd0; ld_we = 1'b0; ld_addr = 10'd0; ld_data = 32'd0;
    prog[0] = 32'h3401_1100; prog[1] = 32'h3402_0020;
    prog[2] = 32'h3403_FF00; prog[3] = 32'h3404_FFFF;

    // Reset two cycles with ce=0.
    cyc(1'b1, 1'b0, 32'd0, 1'b0, 10'd0, 32'd0);
    cyc(1'b1, 1'b0, 32'd0, 1'b0, 10'd0, 32'd0);
    check_resp("reset", 1'b0, 32'd0, 32'd0, 1'b0);
`ifdef INST_ROM_STATS_EN
    check("reset.fetch_cnt", fetch_cnt, 32'd0);
    check("reset.err_cnt", {16'd0, err_cnt}, 32'd0);
`endif
    cyc(1'b0, 1'b0, 32'h0000_0040, 1'b0, 10'd0, 32'd0);
    check_resp("idle", 1'b0, 32'd0, 32'd0, 1'b0);

    // Program load.
    for (int i = 0; i < 4; i++) load(i[9:0], prog[i]);
    load(10'd1023, 32'hDEAD_BEEF);
    load(10'd5, 32'h1111_1111);

    // Back-to-back fetches.
    for (int i = 0; i < 4; i++) begin
      fetch(32'(i * 4));
      check_resp($sformatf("seq%0d", i), 1'b1, prog[i], 32'(i * 4), 1'b0);
    end

    // Error and boundary cases.
    fetch(32'h0000_0006);
    check_resp("misalign", 1'b1, 32'd0, 32'h0000_0006, 1'b1);
    fetch(32'h0000_1000);
    check_resp("oor", 1'b1, 32'd0, 32'h0000_1000, 1'b1);
    fetch(32'h0000_1002);
    check_resp("both", 1'b1, 32'd0, 32'h0000_1002, 1'b1);
    fetch(32'h0000_0FFC);
    check_resp("top", 1'b1, 32'hDEAD_BEEF, 32'h0000_0FFC, 1'b0);
    fetch(32'h8000_0000);
    check_resp("highbit", 1'b1, 32'd0, 32'h8000_0000, 1'b1);

    // Read-before-write on the same index.
    cyc(1'b0, 1'b1, 32'h0000_0014, 1'b1, 10'd5, 32'h2222_2222);
    check_resp("rbw.old", 1'b1, 32'h1111_1111, 32'h0000_0014, 1'b0);
    fetch(32'h0000_0014);
    check_resp("rbw.new", 1'b1, 32'h2222_2222, 32'h0000_0014, 1'b0);

    // ce gap: valid pattern 1,1,0,1 with inst_pc holding during the gap.
    fetch(32'h0000_0000);
    check_resp("gap0", 1'b1, prog[0], 32'h0000_0000, 1'b0);
    fetch(32'h0000_0005);
    check_resp("gap1", 1'b1, 32'd0, 32'h0000_0005, 1'b1);
    fetch(32'h0000_0004);
    check_resp("gap2", 1'b1, prog[1], 32'h0000_0004, 1'b0);
    cyc(1'b0, 1'b0, 32'h0000_0030, 1'b0, 10'd0, 32'd0);
    check_resp("gap3", 1'b0, 32'd0, 32'h0000_0004, 1'b0);
    fetch(32'h0000_0008);
    check_resp("gap4", 1'b1, prog[2], 32'h0000_0008, 1'b0);

    // Reset while ce=1, with a load in the same cycle.
    cyc(1'b1, 1'b1, 32'h0000_000C, 1'b1, 10'd7, 32'hCAFE_0007);
    check_resp("rst_mid", 1'b0, 32'd0, 32'd0, 1'b0);
`ifdef INST_ROM_STATS_EN
    check("rst_mid.fetch_cnt", fetch_cnt, 32'd0);
`endif
    fetch(32'h0000_001C);
    check_resp("rst_load", 1'b1, 32'hCAFE_0007, 32'h0000_001C, 1'b0);

    // 5 good + 2 bad after reset -> 7 accepted, 2 errored (stats build).
    cyc(1'b1, 1'b0, 32'd0, 1'b0, 10'd0, 32'd0);
    fetch(32'h0000_0000);
    fetch(32'h0000_0004);
    fetch(32'h0000_0003);
    fetch(32'h0000_0008);
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 10'd0, 32'd0);
    fetch(32'h0000_000C);
    fetch(32'h0000_2000);
    fetch(32'h0000_0FFC);
    check_resp("stats_last", 1'b1, 32'hDEAD_BEEF, 32'h0000_0FFC, 1'b0);
`ifdef INST_ROM_STATS_EN
    check("stats.fetch_cnt", fetch_cnt, 32'd7);
    check("stats.err_cnt", {16'd0, err_cnt}, 32'd2);
    cyc(1'b1, 1'b0, 32'd0, 1'b0, 10'd0, 32'd0);
    check("stats_rst.fetch_cnt", fetch_cnt, 32'd0);
    check("stats_rst.err_cnt", {16'd0, err_cnt}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
